// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter in front of a shared ALU with two requesters.
// Each granted operation runs IDLE -> EXEC -> RESP; the response is held until
// the consumer accepts it. Illegal op codes (101..111) produce a zero result
// with rsp_err set.
module alu_arbiter #(
   parameter int unsigned SIZE = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [2:0]      req0_op,
   input  logic            req0_sub,
   input  logic [SIZE-1:0] req0_a,
   input  logic [SIZE-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [2:0]      req1_op,
   input  logic            req1_sub,
   input  logic [SIZE-1:0] req1_a,
   input  logic [SIZE-1:0] req1_b,
   output logic [2:0]      alu_sel,
   output logic            alu_sub,
   output logic [SIZE-1:0] alu_a,
   output logic [SIZE-1:0] alu_b,
   input  logic [SIZE-1:0] alu_c,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [SIZE-1:0] rsp_data,
   output logic            rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t          state_q;
   logic            last_q;
   logic [2:0]      sel_q;
   logic            sub_q;
   logic [SIZE-1:0] a_q;
   logic [SIZE-1:0] b_q;
   logic            id_q;
   logic            err_q;
   logic            rsp_valid_q;
   logic            rsp_id_q;
   logic            rsp_err_q;
   logic [SIZE-1:0] rsp_data_q;

   logic            any_valid;
   logic            grant;
   logic            gnt_id;
   logic [2:0]      gnt_op;
   logic            gnt_sub;
   logic [SIZE-1:0] gnt_a;
   logic [SIZE-1:0] gnt_b;
   logic            gnt_illegal;

   // Round-robin winner selection and combinational ready in IDLE
   always_comb begin
      any_valid   = req0_valid | req1_valid;
      gnt_id      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      grant       = rst_n & (state_q == S_IDLE) & any_valid;
      req0_ready  = grant & ~gnt_id;
      req1_ready  = grant & gnt_id;
      gnt_op      = gnt_id ? req1_op  : req0_op;
      gnt_sub     = gnt_id ? req1_sub : req0_sub;
      gnt_a       = gnt_id ? req1_a   : req0_a;
      gnt_b       = gnt_id ? req1_b   : req0_b;
      gnt_illegal = gnt_op[2] & (gnt_op[1] | gnt_op[0]);
   end

   // Sequencer: capture the granted request, sample the ALU, hold the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         sel_q       <= '0;
         sub_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_valid) begin
                  state_q <= S_EXEC;
                  last_q  <= gnt_id;
                  // illegal ops steer the ALU to a benign select
                  sel_q   <= gnt_illegal ? 3'b000 : gnt_op;
                  sub_q   <= gnt_sub;
                  a_q     <= gnt_a;
                  b_q     <= gnt_b;
                  id_q    <= gnt_id;
                  err_q   <= gnt_illegal;
               end
            end
            S_EXEC: begin
               rsp_data_q  <= err_q ? '0 : alu_c;
               rsp_id_q    <= id_q;
               rsp_err_q   <= err_q;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Output mapping from registered state
   always_comb begin
      alu_sel   = sel_q;
      alu_sub   = sub_q;
      alu_a     = a_q;
      alu_b     = b_q;
      rsp_valid = rsp_valid_q;
      rsp_id    = rsp_id_q;
      rsp_err   = rsp_err_q;
      rsp_data  = rsp_data_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand sequences
// for contention/backpressure/reset, and a randomized scoreboard phase.
module tb_alu_arbiter;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, req0_sub;
   logic [2:0]    req0_op;
   logic [W-1:0]  req0_a, req0_b;
   logic          req1_valid, req1_ready, req1_sub;
   logic [2:0]    req1_op;
   logic [W-1:0]  req1_a, req1_b;
   logic [2:0]    alu_sel;
   logic          alu_sub;
   logic [W-1:0]  alu_a, alu_b, alu_c;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [W-1:0]  rsp_data;

   int tests = 0;
   int fails = 0;

   alu_arbiter #(.SIZE(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_sub(req0_sub), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_sub(req1_sub), .req1_a(req1_a), .req1_b(req1_b),
      .alu_sel(alu_sel), .alu_sub(alu_sub), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Shared ALU environment model; unused selects return a marker value
   always_comb begin
      case (alu_sel)
         3'd0:    alu_c = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
         3'd1:    alu_c = alu_a & alu_b;
         3'd2:    alu_c = alu_a | alu_b;
         3'd3:    alu_c = alu_a ^ alu_b;
         3'd4:    alu_c = alu_sub ? (alu_a >> alu_b[4:0]) : (alu_a << alu_b[4:0]);
         default: alu_c = 32'hDEAD_BEEF;
      endcase
   end

   // Expected response data for a request, straight from the op definitions
   function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic sub,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned sh;
      sh = b % W;
      case (op)
         3'd0:    return sub ? a - b : a + b;
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a ^ b;
         3'd4:    return sub ? a >> sh : a << sh;
         default: return '0;
      endcase
   endfunction

   function automatic logic is_illegal(input logic [2:0] op);
      return op > 3'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_req(input logic id, input logic v, input logic [2:0] op,
                            input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!id) begin
         req0_valid = v; req0_op = op; req0_sub = sub; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_sub = sub; req1_a = a; req1_b = b;
      end
   endtask

   function automatic logic [31:0] rdy();
      return 32'({req1_ready, req0_ready});
   endfunction

   task automatic apply_reset();
      drive_req(1'b0, 1'b0, 3'd0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
      rsp_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One isolated transaction from IDLE, consumed at the first RESP cycle
   task automatic do_txn(input logic id, input logic [2:0] op, input logic sub,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic ee);
      @(negedge clk);
      drive_req(id, 1'b1, op, sub, a, b);
      #1;
      chk("txn_grant", rdy(), id ? 32'd2 : 32'd1);
      @(negedge clk);
      drive_req(id, 1'b0, 3'd0, 1'b0, '0, '0);
      #1;
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_ready", rdy(), 32'd0);
      chk("exec_alu_sel", 32'(alu_sel), ee ? 32'd0 : 32'(op));
      @(negedge clk);
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_data", rsp_data, ed);
      chk("resp_id", 32'(rsp_id), 32'(id));
      chk("resp_err", 32'(rsp_err), 32'(ee));
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("resp_drop", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic         id;
      logic [2:0]   op;
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_data;
      logic         exp_err;
   } vec_t;

   typedef struct {
      logic         id;
      logic [W-1:0] data;
      logic         err;
      int           gcyc;
   } exp_t;

   vec_t  vecs[11];
   exp_t  sb[$];
   exp_t  e;
   logic  last_gnt, busy, exp_valid, pop, v0, v1, rr, w;
   logic [2:0]   op0, op1;
   logic [W-1:0] a0, b0, a1, b1, ed;
   logic         s0, s1;

   initial begin
      vecs[0]  = '{1'b0, 3'd0, 1'b0, 32'd5,        32'd3,        32'd8,          1'b0};
      vecs[1]  = '{1'b1, 3'd0, 1'b1, 32'd5,        32'd3,        32'd2,          1'b0};
      vecs[2]  = '{1'b0, 3'd0, 1'b1, 32'd3,        32'd5,        32'hFFFF_FFFE,  1'b0};
      vecs[3]  = '{1'b1, 3'd1, 1'b0, 32'hF0F0,     32'h0FF0,     32'h00F0,       1'b0};
      vecs[4]  = '{1'b0, 3'd2, 1'b0, 32'hF0F0,     32'h0FF0,     32'hFFF0,       1'b0};
      vecs[5]  = '{1'b1, 3'd3, 1'b0, 32'hF0F0,     32'h0FF0,     32'hFF00,       1'b0};
      vecs[6]  = '{1'b0, 3'd4, 1'b0, 32'd1,        32'd4,        32'h10,         1'b0};
      vecs[7]  = '{1'b1, 3'd4, 1'b1, 32'h80,       32'd3,        32'h10,         1'b0};
      vecs[8]  = '{1'b0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,          1'b0};
      vecs[9]  = '{1'b1, 3'd6, 1'b0, 32'h1234,     32'h5678,     32'd0,          1'b1};
      vecs[10] = '{1'b0, 3'd7, 1'b1, 32'hFFFF,     32'h1,        32'd0,          1'b1};

      // Reset state, with both requesters asserting valid during reset
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      drive_req(1'b0, 1'b1, 3'd0, 1'b0, 32'd1, 32'd1);
      drive_req(1'b1, 1'b1, 3'd1, 1'b0, 32'd1, 32'd1);
      #3;
      chk("rst_ready", rdy(), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'd0);
      chk("rst_alu_sub", 32'(alu_sub), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      @(negedge clk);
      apply_reset();

      // Directed vector table
      for (int i = 0; i < 11; i++)
         do_txn(vecs[i].id, vecs[i].op, vecs[i].sub, vecs[i].a, vecs[i].b,
                vecs[i].exp_data, vecs[i].exp_err);

      // Contention after reset: 0 wins first, then strict alternation
      apply_reset();
      drive_req(1'b0, 1'b1, 3'd3, 1'b0, 32'hF0F0, 32'h0FF0);
      drive_req(1'b1, 1'b1, 3'd1, 1'b0, 32'hF0F0, 32'h0FF0);
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("cont_grant", rdy(), (k % 2) ? 32'd2 : 32'd1);
         @(negedge clk);
         chk("cont_exec_valid", 32'(rsp_valid), 32'd0);
         @(negedge clk);
         chk("cont_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("cont_rsp_id", 32'(rsp_id), 32'(k % 2));
         chk("cont_rsp_data", rsp_data, (k % 2) ? 32'h00F0 : 32'hFF00);
         @(negedge clk);
      end
      drive_req(1'b0, 1'b0, 3'd0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
      rsp_ready = 1'b0;

      // Backpressure: response held 5 cycles while req1 waits
      @(negedge clk);
      drive_req(1'b0, 1'b1, 3'd2, 1'b0, 32'h1, 32'h2);
      #1;
      chk("bp_grant0", rdy(), 32'd1);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 3'd0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b1, 3'd0, 1'b0, 32'd10, 32'd20);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data", rsp_data, 32'd3);
         chk("bp_id", 32'(rsp_id), 32'd0);
         chk("bp_ready", rdy(), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_last_ready", rdy(), 32'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("bp_next_grant", rdy(), 32'd2);
      chk("bp_released", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      drive_req(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
      @(negedge clk);
      chk("bp2_data", rsp_data, 32'd30);
      chk("bp2_id", 32'(rsp_id), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset mid-RESP: response vanishes immediately
      drive_req(1'b1, 1'b1, 3'd0, 1'b0, 32'd2, 32'd3);
      #1;
      chk("mr_grant", rdy(), 32'd2);
      @(negedge clk);
      drive_req(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
      @(negedge clk);
      chk("mr_pre_valid", 32'(rsp_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(rsp_valid), 32'd0);
      chk("mr_data", rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-EXEC after a req0 grant; pointer must return to favour req0
      @(negedge clk);
      drive_req(1'b0, 1'b1, 3'd0, 1'b0, 32'd7, 32'd8);
      #1;
      chk("me_grant", rdy(), 32'd1);
      @(negedge clk);
      drive_req(1'b1, 1'b1, 3'd1, 1'b0, 32'hF, 32'h3);
      #1 rst_n = 1'b0;
      #1;
      chk("me_valid", 32'(rsp_valid), 32'd0);
      chk("me_ready_in_rst", rdy(), 32'd0);
      @(negedge clk);
      chk("me_no_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("me_post_grant", rdy(), 32'd1);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 3'd0, 1'b0, '0, '0);
      drive_req(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
      chk("me_post_exec", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("me_post_data", rsp_data, 32'd15);
      chk("me_post_id", 32'(rsp_id), 32'd0);
      @(negedge clk);
      chk("me_post_idle", 32'(rsp_valid), 32'd0);

      // Back-to-back: req1 alone, valid held, rsp_ready high -> every 3 cycles
      for (int k = 0; k < 5; k++) begin
         op1 = 3'($urandom_range(0, 4));
         s1 = 1'($urandom_range(0, 1));
         a1 = $urandom;
         b1 = $urandom;
         drive_req(1'b1, 1'b1, op1, s1, a1, b1);
         ed = ref_result(op1, s1, a1, b1);
         #1;
         chk("b2b_grant", rdy(), 32'd2);
         @(negedge clk);
         chk("b2b_exec_ready", rdy(), 32'd0);
         @(negedge clk);
         chk("b2b_valid", 32'(rsp_valid), 32'd1);
         chk("b2b_data", rsp_data, ed);
         @(negedge clk);
      end
      drive_req(1'b1, 1'b0, 3'd0, 1'b0, '0, '0);
      rsp_ready = 1'b0;

      // Randomized traffic against a transaction-level scoreboard
      apply_reset();
      last_gnt = 1'b1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc != 0) @(negedge clk);
         busy = (sb.size() != 0);
         pop = 1'b0;
         exp_valid = 1'b0;
         if (busy) begin
            exp_valid = (cyc >= sb[0].gcyc + 2);
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
               chk("rnd_rsp_data", rsp_data, sb[0].data);
               chk("rnd_rsp_id", 32'(rsp_id), 32'(sb[0].id));
               chk("rnd_rsp_err", 32'(rsp_err), 32'(sb[0].err));
            end
         end else begin
            chk("rnd_idle_valid", 32'(rsp_valid), 32'd0);
         end
         rr = ($urandom_range(0, 3) != 0);
         rsp_ready = rr;
         pop = exp_valid & rr;
         v0 = ($urandom_range(0, 2) != 0);
         v1 = ($urandom_range(0, 2) != 0);
         op0 = 3'($urandom_range(0, 7));
         op1 = 3'($urandom_range(0, 7));
         s0 = 1'($urandom_range(0, 1));
         s1 = 1'($urandom_range(0, 1));
         a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
         drive_req(1'b0, v0, op0, s0, a0, b0);
         drive_req(1'b1, v1, op1, s1, a1, b1);
         #1;
         if (!busy && (v0 || v1)) begin
            w = (v0 && v1) ? ~last_gnt : v1;
            chk("rnd_grant", rdy(), w ? 32'd2 : 32'd1);
            e.id   = w;
            e.data = w ? ref_result(op1, s1, a1, b1) : ref_result(op0, s0, a0, b0);
            e.err  = w ? is_illegal(op1) : is_illegal(op0);
            e.gcyc = cyc;
            sb.push_back(e);
            last_gnt = w;
         end else begin
            chk("rnd_no_grant", rdy(), 32'd0);
         end
         if (pop) void'(sb.pop_front());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
